// File: rtl/fpga_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for the LUT-array configuration controller:
//   CFG_WORD_W  - width of one 4-input LUT truth table (16 bits)
//   MAX_LUTS    - upper bound on array size supported by the onehot() helper
//   cfg_state_e - controller state encoding (3 bits)
//   onehot()    - index to one-hot write-enable vector
// -----------------------------------------------------------------------------
package fpga_cfg_pkg;

   localparam int CFG_WORD_W = 16;
   localparam int MAX_LUTS   = 1024;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } cfg_state_e;

   // Returns a MAX_LUTS-wide vector with only bit idx set; callers truncate
   // the result to their own array width.
   function automatic logic [MAX_LUTS-1:0] onehot(input int unsigned idx);
      logic [MAX_LUTS-1:0] one;
      one = {{(MAX_LUTS-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/fpga_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// fpga_cfg_ctrl
// Loads NUM_LUTS 16-bit truth-table words, received over a valid/ready stream,
// into successive LUT cells through a one-hot write-enable bus, and holds the
// fabric enable low until the whole array has been written.
//
// Optional feature (macro FPGA_CFG_CHECKSUM_EN): after the NUM_LUTS words one
// extra trailer word is accepted and compared with the XOR of all loaded
// words; a mismatch lands in ERR with err_o set and the fabric left disabled.
// Without the macro err_o is tied low and ERR is unreachable.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   start_i      in   begin a (re)configuration pass from IDLE/DONE/ERR
//   cfg_data_i   in   [16] truth-table word (bit n = output for input n)
//   cfg_valid_i  in   cfg_data_i valid
//   cfg_ready_o  out  controller accepts a word this cycle
//   lut_data_o   out  [16] word broadcast to all LUTs
//   lut_we_o     out  [NUM_LUTS] one-hot single-cycle write enable
//   lut_en_o     out  fabric outputs valid (DONE only)
//   busy_o       out  pass in progress (LOAD/CHECK)
//   done_o       out  array fully configured
//   err_o        out  checksum mismatch (macro builds only, else 0)
// All outputs are registered.
// -----------------------------------------------------------------------------
module fpga_cfg_ctrl
   import fpga_cfg_pkg::*;
#(
   parameter int NUM_LUTS = 8,
   parameter int IDX_W    = $clog2(NUM_LUTS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CFG_WORD_W-1:0] cfg_data_i,
   input  logic                  cfg_valid_i,
   output logic                  cfg_ready_o,
   output logic [CFG_WORD_W-1:0] lut_data_o,
   output logic [NUM_LUTS-1:0]   lut_we_o,
   output logic                  lut_en_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   cfg_state_e            state_reg;
   logic [IDX_W-1:0]      idx_reg;
   logic                  cfg_ready_reg;
   logic [CFG_WORD_W-1:0] lut_data_reg;
   logic [NUM_LUTS-1:0]   lut_we_reg;
   logic                  lut_en_reg;
   logic                  busy_reg;
   logic                  done_reg;
`ifdef FPGA_CFG_CHECKSUM_EN
   logic [CFG_WORD_W-1:0] acc_reg;
   logic                  err_reg;
`endif

   logic xfer;
   logic last_word;

   // ready is registered, so a transfer is fully determined by the
   // registered ready and the incoming valid.
   assign xfer      = cfg_valid_i & cfg_ready_reg;
   assign last_word = (idx_reg == IDX_W'(NUM_LUTS - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         cfg_ready_reg <= 1'b0;
         lut_data_reg  <= '0;
         lut_we_reg    <= '0;
         lut_en_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
         acc_reg       <= '0;
         err_reg       <= 1'b0;
`endif
      end else begin
         // Write enable is a single-cycle pulse unless a transfer re-arms it.
         lut_we_reg <= '0;

         case (state_reg)
            // A pass can be (re)started from any resting state; clearing
            // done/en here is what drops the fabric enable the cycle after
            // start_i.
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  state_reg     <= LOAD;
                  idx_reg       <= '0;
                  cfg_ready_reg <= 1'b1;
                  busy_reg      <= 1'b1;
                  done_reg      <= 1'b0;
                  lut_en_reg    <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
                  acc_reg       <= '0;
                  err_reg       <= 1'b0;
`endif
               end
            end

            // start_i is deliberately not looked at here.
            LOAD: begin
               if (xfer) begin
                  lut_data_reg <= cfg_data_i;
                  lut_we_reg   <= NUM_LUTS'(onehot(32'(idx_reg)));
`ifdef FPGA_CFG_CHECKSUM_EN
                  acc_reg      <= acc_reg ^ cfg_data_i;
`endif
                  if (last_word) begin
`ifdef FPGA_CFG_CHECKSUM_EN
                     // ready stays high to take the trailer word.
                     state_reg     <= CHECK;
`else
                     state_reg     <= DONE;
                     cfg_ready_reg <= 1'b0;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
                     lut_en_reg    <= 1'b1;
`endif
                  end else begin
                     // Index holds at NUM_LUTS-1 after the last word, so it
                     // never wraps within a pass.
                     idx_reg <= idx_reg + IDX_W'(1);
                  end
               end
            end

`ifdef FPGA_CFG_CHECKSUM_EN
            // The trailer is compared, never written to a LUT.
            CHECK: begin
               if (xfer) begin
                  cfg_ready_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  if (cfg_data_i == acc_reg) begin
                     state_reg  <= DONE;
                     done_reg   <= 1'b1;
                     lut_en_reg <= 1'b1;
                  end else begin
                     state_reg  <= ERR;
                     err_reg    <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state_reg     <= IDLE;
               cfg_ready_reg <= 1'b0;
               busy_reg      <= 1'b0;
               done_reg      <= 1'b0;
               lut_en_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready_o = cfg_ready_reg;
   assign lut_data_o  = lut_data_reg;
   assign lut_we_o    = lut_we_reg;
   assign lut_en_o    = lut_en_reg;
   assign busy_o      = busy_reg;
   assign done_o      = done_reg;
`ifdef FPGA_CFG_CHECKSUM_EN
   assign err_o       = err_reg;
`else
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_ctrl
// Scoreboard bench for fpga_cfg_ctrl (NUM_LUTS = 8). Stimulus pushes the
// expected LUT writes and pass outcomes into queues; an independent monitor
// on the falling edge pops and compares whenever lut_we_o pulses or
// done_o/err_o rises. Checksum scenarios are compiled in only when
// FPGA_CFG_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_ctrl;

   localparam int N = 8;

   typedef struct {
      int          idx;
      logic [15:0] data;
   } we_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_data = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [15:0] lut_data;
   logic [N-1:0] lut_we;
   logic        lut_en;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   we_exp_t    we_q[$];
   logic [2:0] stat_q[$];   // {done, err, en} expected when a pass ends

   always #5 clk = ~clk;

   fpga_cfg_ctrl #(.NUM_LUTS(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .cfg_data_i  (cfg_data),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .lut_data_o  (lut_data),
      .lut_we_o    (lut_we),
      .lut_en_o    (lut_en),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // ---------------- monitor ----------------
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;

   always @(negedge clk) begin
      if (lut_we != '0) begin
         if (we_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_we: got we=%0h data=%0h expected no write at %0t",
                     lut_we, lut_data, $time);
         end else begin
            we_exp_t    e;
            logic [N-1:0] ev;
            e  = we_q.pop_front();
            ev = N'(1) << e.idx;
            total++;
            if (lut_we !== ev || lut_data !== e.data) begin
               bad++;
               $display("FAIL lut_write: got we=%0h data=%0h expected we=%0h data=%0h at %0t",
                        lut_we, lut_data, ev, e.data, $time);
            end else begin
               $display("ok   lut_write idx=%0d data=%0h", e.idx, lut_data);
            end
         end
      end
      if ((done && !prev_done) || (err && !prev_err)) begin
         if (stat_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_end: got done=%0b err=%0b en=%0b with nothing expected at %0t",
                     done, err, lut_en, $time);
         end else begin
            logic [2:0] s;
            s = stat_q.pop_front();
            total++;
            if ({done, err, lut_en} !== s) begin
               bad++;
               $display("FAIL pass_end: got {done,err,en}=%3b expected %3b at %0t",
                        {done, err, lut_en}, s, $time);
            end else begin
               $display("ok   pass_end {done,err,en}=%3b", s);
            end
         end
      end
      prev_done = done;
      prev_err  = err;
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send(input logic [15:0] w, input int idx, input bit is_write);
      int n = 0;
      cfg_valid = 1'b1;
      cfg_data  = w;
      while (!cfg_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) begin
         total++; bad++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 for word %0h", w);
      end else if (is_write) begin
         we_q.push_back('{idx: idx, data: w});
      end
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Loads N words (plus trailer in checksum builds), optional 3-cycle valid
   // gap before word index stall_at, then checks the end-of-pass outputs.
   task automatic load_words(input logic [15:0] w[N], input logic [15:0] trailer,
                             input bit exp_ok, input int stall_at);
      for (int i = 0; i < N; i++) begin
         if (i == stall_at) repeat (3) @(negedge clk);
`ifndef FPGA_CFG_CHECKSUM_EN
         if (i == N - 1) stat_q.push_back(3'b101);
`endif
         send(w[i], i, 1'b1);
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      stat_q.push_back(exp_ok ? 3'b101 : 3'b010);
      send(trailer, 0, 1'b0);
`endif
      chk("end_done",  32'(done),      32'(exp_ok));
      chk("end_err",   32'(err),       32'(!exp_ok));
      chk("end_en",    32'(lut_en),    32'(exp_ok));
      chk("end_ready", 32'(cfg_ready), 32'd0);
      chk("end_busy",  32'(busy),      32'd0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_ready", 32'(cfg_ready), 32'd1);
      chk("start_busy",  32'(busy),      32'd1);
      chk("start_en",    32'(lut_en),    32'd0);
   endtask

   logic [15:0] seq_w[N];
   logic [15:0] ck_w[N];

   initial begin
      for (int i = 0; i < N; i++) seq_w[i] = 16'(i + 1);
      ck_w[0] = 16'hAAAA; ck_w[1] = 16'h5555;
      for (int i = 2; i < N; i++) ck_w[i] = 16'h0000;

      // reset
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_en",    32'(lut_en),    32'd0);
      chk("rst_err",   32'(err),       32'd0);
      chk("rst_we",    32'(lut_we),    32'd0);
      chk("rst_data",  32'(lut_data),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(cfg_ready), 32'd0);

      // back-to-back pass, 1..8 (XOR of 1..8 = 8)
      start_pulse();
      load_words(seq_w, 16'h0008, 1'b1, -1);

      // same stream with a 3-cycle valid gap after word 2
      start_pulse();
      load_words(seq_w, 16'h0008, 1'b1, 2);

`ifdef FPGA_CFG_CHECKSUM_EN
      // AAAA ^ 5555 = FFFF
      start_pulse();
      load_words(ck_w, 16'hFFFF, 1'b1, -1);
      start_pulse();
      load_words(ck_w, 16'hFFFE, 1'b0, -1);
`endif

      // reset mid-pass after 4 words; word 5 offered with reset must not write
      start_pulse();
      for (int i = 0; i < 4; i++) send(seq_w[i], i, 1'b1);
      cfg_valid = 1'b1;
      cfg_data  = seq_w[4];
      rst = 1'b1;
      start = 1'b1;          // reset must win over start
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      cfg_valid = 1'b0;
      chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
      chk("mid_rst_busy",  32'(busy),      32'd0);
      chk("mid_rst_we",    32'(lut_we),    32'd0);
      chk("mid_rst_en",    32'(lut_en),    32'd0);
      chk("mid_rst_data",  32'(lut_data),  32'd0);
      @(negedge clk);
      chk("mid_rst_idle",  32'(cfg_ready), 32'd0);
      start_pulse();
      load_words(seq_w, 16'h0008, 1'b1, -1);

      // start held 5 cycles in DONE starts exactly one pass from index 0
      start = 1'b1;
      @(negedge clk);
      chk("hold_en",    32'(lut_en),    32'd0);
      chk("hold_done",  32'(done),      32'd0);
      chk("hold_ready", 32'(cfg_ready), 32'd1);
      repeat (4) @(negedge clk);
      start = 1'b0;
      chk("hold_busy", 32'(busy), 32'd1);
      load_words(seq_w, 16'h0008, 1'b1, -1);

      repeat (3) @(negedge clk);
      chk("we_queue_empty",   32'(we_q.size()),   32'd0);
      chk("stat_queue_empty", 32'(stat_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fpga_cfg_ctrl.md
# fpga_cfg_ctrl

Configuration controller for an array of `NUM_LUTS` 4-input LUT cells.
- Accepts a stream of 16-bit truth-table words over a valid/ready handshake.
- Writes each word into successive LUTs through a one-hot write-enable bus.
- Gates the fabric enable until the whole array is loaded.
- Sits between the configuration port (host or bitstream loader) and the LUT array.

## Interface
Parameters:
- `NUM_LUTS`, default 8: number of LUT cells driven; must be ≥ 2.
- `IDX_W`, default `$clog2(NUM_LUTS)`: LUT index counter width; derived, not overridden.

Ports:
- `clk_i` input, 1: single clock; all logic is rising-edge.
- `rst_i` input, 1: reset, synchronous, active-high.
- `start_i` input, 1: begin a (re)configuration pass.
- `cfg_data_i` input, 16: truth-table word; bit n is the LUT output for input value n.
- `cfg_valid_i` input, 1: `cfg_data_i` is valid.
- `cfg_ready_o` output, 1: controller accepts a word this cycle.
- `lut_data_o` output, 16: word broadcast to all LUTs.
- `lut_we_o` output, `NUM_LUTS`: one-hot write enable, single-cycle pulse.
- `lut_en_o` output, 1: fabric outputs valid; high only in DONE.
- `busy_o` output, 1: pass in progress (LOAD or CHECK).
- `done_o` output, 1: array fully configured.
- `err_o` output, 1: checksum mismatch. Present only with the macro; tied 0 otherwise.

## Operation
- FSM states: IDLE, LOAD, CHECK (macro only), DONE, ERR. All outputs are registered.
- **IDLE**
  - `start_i` → LOAD, index cleared to 0, checksum accumulator cleared to 0.
- **LOAD**
  - `cfg_ready_o` = 1.
  - Each transfer (`cfg_valid_i & cfg_ready_o`) registers `lut_data_o <= cfg_data_i` and pulses `lut_we_o[index]` in the next cycle.
  - Index increments on each transfer.
  - The transfer of word `NUM_LUTS-1` exits LOAD: → DONE without the macro, → CHECK with it.
  - `cfg_valid_i` low stalls with no write. `start_i` is ignored.
- **CHECK** (macro only)
  - `cfg_ready_o` = 1 for exactly one trailer word.
  - On transfer, compare it against the XOR of all `NUM_LUTS` accepted words.
  - Match → DONE. Mismatch → ERR.
- **DONE**
  - `done_o` = 1, `lut_en_o` = 1.
  - `start_i` → LOAD. Drops `lut_en_o`/`done_o` the next cycle and clears index and accumulator.
- **ERR**
  - `err_o` = 1, `lut_en_o` = 0.
  - `start_i` → LOAD, same clearing as above.
- `lut_we_o` is never multi-hot.
- Index never exceeds `NUM_LUTS-1`. No wrap-around inside one pass.
- The block never reads back LUT contents.

## Timing
- Reset values:
  - state IDLE, index 0, accumulator 0.
  - `cfg_ready_o`, `lut_we_o`, `lut_en_o`, `busy_o`, `done_o`, `err_o` = 0.
  - `lut_data_o` = 16'h0000.
- `start_i` at cycle t → `cfg_ready_o` and `busy_o` high at t+1.
- Transfer at cycle t → `lut_we_o[k]` high and `lut_data_o` = word at t+1, for exactly one cycle.
- Back-to-back transfers sustain one word per cycle. A full pass with no stalls is `NUM_LUTS` cycles in LOAD.
- Last-word transfer at t, no macro:
  - `lut_we_o[NUM_LUTS-1]` high at t+1.
  - `done_o`/`lut_en_o` high at t+1.
  - `cfg_ready_o` low at t+1.
- Trailer transfer at t, macro: `done_o` or `err_o` high at t+1. No `lut_we_o` pulse for the trailer.
- `start_i` held high across several cycles in DONE/ERR starts exactly one pass. Further `start_i` while in LOAD is ignored.
- `rst_i` mid-pass:
  - Next cycle is IDLE with reset output values.
  - Any pending `lut_we_o` pulse is cancelled.
  - LUT contents are left as partially written; `lut_en_o` stays 0 until a later full pass completes.
- `rst_i` has priority over `start_i` in the same cycle.

## Configuration
- Macro `FPGA_CFG_CHECKSUM_EN`.
- Defined:
  - CHECK state, XOR accumulator and `err_o` logic are compiled in.
  - A pass is `NUM_LUTS` + 1 words.
- Undefined:
  - No CHECK state, no accumulator.
  - `err_o` tied 0; ERR unreachable.
  - A pass is `NUM_LUTS` words.

## Structure
- Package `fpga_cfg_pkg`:
  - `CFG_WORD_W` = 16.
  - State enum `cfg_state_e` (IDLE, LOAD, CHECK, DONE, ERR), 3-bit encoding.
  - Helper function `onehot(idx)`.
- No sub-module. FSM, index counter and accumulator live in `fpga_cfg_ctrl`. The LUT array is instantiated by the parent.

## Test plan
- Reset, then `start_i`, `NUM_LUTS`=8, words 16'h0001..16'h0008 back-to-back → `lut_we_o` walks 8'h01..8'h80 on consecutive cycles with matching `lut_data_o`; `done_o`/`lut_en_o` high the cycle after the last transfer.
- Same stream with `cfg_valid_i` dropped 3 cycles after word 2 → no `lut_we_o` during the gap; the rest of the sequence is unchanged.
- Macro on, words 16'hAAAA, 16'h5555, then 6×16'h0000, trailer 16'hFFFF → DONE. Repeat with trailer 16'hFFFE → `err_o`=1, `lut_en_o`=0.
- `rst_i` asserted after word 4 accepted → all outputs 0 next cycle, no `lut_we_o[4]` pulse; new `start_i` reloads from index 0.
- In DONE, `start_i` held 5 cycles → `lut_en_o` falls next cycle, exactly one pass begins, index restarts at 0.
